// File: rtl/sc_edge_detector_param.sv
// sc_edge_detector_param: stochastic-computing Roberts-cross edge detector.
// Four WIDTH-bit pixels are turned into correlated deterministic bitstreams.
// |a-b| is an XOR of two streams, the two diagonals are merged by MUX
// (scaled) addition, and the output stream is emitted serially and counted.
// Optional feature macro: SC_EDGE_THRESH_EN adds the thresh input and the
// registered edge_hit output (mag >= thresh). The output cannot be called
// "edge" because that name is a SystemVerilog keyword.
module sc_edge_detector_param #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] r00,
    input  logic [WIDTH-1:0] r01,
    input  logic [WIDTH-1:0] r10,
    input  logic [WIDTH-1:0] r11,
    output logic             busy,
    output logic             s,
    output logic             s_valid,
    output logic [WIDTH:0]   mag,
    output logic             done
`ifdef SC_EDGE_THRESH_EN
    ,
    input  logic [WIDTH:0]   thresh,
    output logic             edge_hit
`endif
);

    localparam int unsigned CW = WIDTH + 1;
    localparam logic [CW-1:0] K_LAST = '1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [CW-1:0]     k_q, k_d;
    logic [CW-1:0]     acc_q, acc_d;
    logic [WIDTH-1:0]  p00_q, p00_d, p01_q, p01_d, p10_q, p10_d, p11_q, p11_d;
    logic              busy_q, busy_d;
    logic              s_q, s_d;
    logic              s_valid_q, s_valid_d;
    logic [CW-1:0]     mag_q, mag_d;
    logic              done_q, done_d;
`ifdef SC_EDGE_THRESH_EN
    logic              edge_q, edge_d;
`endif

    logic [WIDTH-1:0]  x_c;
    logic              bit_c;

    // Shared source value: bit-reverse of k[WIDTH:1], then the MUX-added XOR streams
    always_comb begin
        x_c = '0;
        for (int i = 0; i < int'(WIDTH); i++) begin
            x_c[i] = k_q[int'(WIDTH) - i];
        end
        bit_c = k_q[0] ? ((p10_q > x_c) ^ (p01_q > x_c))
                       : ((p00_q > x_c) ^ (p11_q > x_c));
    end

    // Next-state and registered-output logic
    always_comb begin
        state_d   = state_q;
        k_d       = k_q;
        acc_d     = acc_q;
        p00_d     = p00_q;
        p01_d     = p01_q;
        p10_d     = p10_q;
        p11_d     = p11_q;
        s_d       = 1'b0;
        s_valid_d = 1'b0;
        done_d    = 1'b0;
        mag_d     = mag_q;
`ifdef SC_EDGE_THRESH_EN
        edge_d    = edge_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    p00_d   = r00;
                    p01_d   = r01;
                    p10_d   = r10;
                    p11_d   = r11;
                    k_d     = '0;
                    acc_d   = '0;
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                s_d       = bit_c;
                s_valid_d = 1'b1;
                acc_d     = acc_q + CW'(bit_c);
                k_d       = k_q + CW'(1);
                if (k_q == K_LAST) begin
                    // final count is exact and fits CW bits, no saturation
                    mag_d   = acc_d;
                    done_d  = 1'b1;
                    state_d = S_DONE;
`ifdef SC_EDGE_THRESH_EN
                    edge_d  = (acc_d >= thresh);
`endif
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
        busy_d = (state_d == S_RUN);
    end

    // State and output registers, asynchronous active-high reset
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= S_IDLE;
            k_q       <= '0;
            acc_q     <= '0;
            p00_q     <= '0;
            p01_q     <= '0;
            p10_q     <= '0;
            p11_q     <= '0;
            busy_q    <= 1'b0;
            s_q       <= 1'b0;
            s_valid_q <= 1'b0;
            mag_q     <= '0;
            done_q    <= 1'b0;
`ifdef SC_EDGE_THRESH_EN
            edge_q    <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            k_q       <= k_d;
            acc_q     <= acc_d;
            p00_q     <= p00_d;
            p01_q     <= p01_d;
            p10_q     <= p10_d;
            p11_q     <= p11_d;
            busy_q    <= busy_d;
            s_q       <= s_d;
            s_valid_q <= s_valid_d;
            mag_q     <= mag_d;
            done_q    <= done_d;
`ifdef SC_EDGE_THRESH_EN
            edge_q    <= edge_d;
`endif
        end
    end

    assign busy    = busy_q;
    assign s       = s_q;
    assign s_valid = s_valid_q;
    assign mag     = mag_q;
    assign done    = done_q;
`ifdef SC_EDGE_THRESH_EN
    assign edge_hit = edge_q;
`endif

endmodule

// File: tb/tb_sc_edge_detector_param.sv
// Directed bench for sc_edge_detector_param at WIDTH=4 (N=32).
// Works with or without SC_EDGE_THRESH_EN defined.
module tb_sc_edge_detector_param;

    localparam int unsigned WIDTH = 4;
    localparam int unsigned N     = 32;

    logic             clk = 1'b0;
    logic             rst;
    logic             start;
    logic [WIDTH-1:0] r00, r01, r10, r11;
    logic             busy, s, s_valid, done;
    logic [WIDTH:0]   mag;
    logic [WIDTH:0]   thresh;
    logic             edge_hit;

    int n_vec = 0;
    int n_miscmp = 0;

    sc_edge_detector_param #(.WIDTH(WIDTH)) dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .r00     (r00),
        .r01     (r01),
        .r10     (r10),
        .r11     (r11),
        .busy    (busy),
        .s       (s),
        .s_valid (s_valid),
        .mag     (mag),
        .done    (done)
`ifdef SC_EDGE_THRESH_EN
        ,
        .thresh  (thresh),
        .edge_hit(edge_hit)
`endif
    );

`ifndef SC_EDGE_THRESH_EN
    assign edge_hit = 1'b0;
`endif

    always #5 clk = ~clk;

    // Count one comparison and report it if it does not match
    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miscmp++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    // One start pulse, full run observed cycle by cycle, pixels scrambled mid-run
    task automatic run_vec(input string tag,
                           input logic [WIDTH-1:0] a00, input logic [WIDTH-1:0] a11,
                           input logic [WIDTH-1:0] a10, input logic [WIDTH-1:0] a01,
                           input logic [WIDTH:0] th, input int exp_mag, input int exp_edge);
        int ones, vcnt, bcnt, done_at, done_cnt;
        @(negedge clk);
        r00 = a00; r11 = a11; r10 = a10; r01 = a01;
        thresh = th;
        start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        chk({tag, "_busy_e0"}, 32'(busy), 32'd1);
        chk({tag, "_sv_e0"}, 32'(s_valid), 32'd0);
        ones = 0; vcnt = 0; bcnt = 1; done_at = 0; done_cnt = 0;
        for (int i = 1; i <= int'(N) + 1; i++) begin
            @(posedge clk);
            @(negedge clk);
            if (i == 3) begin
                r00 = ~a00; r11 = ~a11; r10 = ~a10; r01 = ~a01;
            end
            if (s_valid) begin
                vcnt++;
                ones += int'(s);
            end
            if (busy) bcnt++;
            if (done) begin
                done_cnt++;
                if (done_at == 0) done_at = i;
            end
        end
        chk({tag, "_valid_cycles"}, 32'(vcnt), 32'(N));
        chk({tag, "_busy_cycles"}, 32'(bcnt), 32'(N));
        chk({tag, "_ones"}, 32'(ones), 32'(exp_mag));
        // edges from start sample to done-high, counting the sample edge
        chk({tag, "_latency"}, 32'(done_at + 1), 32'(N + 1));
        chk({tag, "_done_pulses"}, 32'(done_cnt), 32'd1);
        chk({tag, "_mag"}, 32'(mag), 32'(exp_mag));
`ifdef SC_EDGE_THRESH_EN
        chk({tag, "_edge"}, 32'(edge_hit), 32'(exp_edge));
`else
        if (exp_edge < 0) chk({tag, "_edge"}, 32'(edge_hit), 32'd0);
`endif
    endtask

    initial begin
        int d1, d2, d3, m1, m2, m3, ndone;
        rst = 1'b1; start = 1'b0;
        r00 = '0; r01 = '0; r10 = '0; r11 = '0; thresh = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_s", 32'(s), 32'd0);
        chk("rst_sv", 32'(s_valid), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_mag", 32'(mag), 32'd0);
`ifdef SC_EDGE_THRESH_EN
        chk("rst_edge", 32'(edge_hit), 32'd0);
`endif
        rst = 1'b0;

        // |12-3| + |5-9| = 13
        run_vec("basic", 4'd12, 4'd3, 4'd5, 4'd9, 5'd13, 13, 1);
        // uniform window: no ones at all
        run_vec("uniform", 4'd7, 4'd7, 4'd7, 4'd7, 5'd1, 0, 0);
        // 15 + 15 = 30, largest possible count
        run_vec("max", 4'd15, 4'd0, 4'd0, 4'd15, 5'd30, 30, 1);
        // same magnitude, threshold just above
        run_vec("max_hi_th", 4'd0, 4'd15, 4'd15, 4'd0, 5'd31, 30, 0);
        // |3-10| + |8-1| = 14, threshold just above
        run_vec("mixed", 4'd3, 4'd10, 4'd1, 4'd8, 5'd15, 14, 0);

        // start held high: results spaced N+2 cycles apart
        @(negedge clk);
        r00 = 4'd12; r11 = 4'd3; r10 = 4'd5; r01 = 4'd9; thresh = 5'd13;
        start = 1'b1;
        d1 = 0; d2 = 0; d3 = 0; m1 = 0; m2 = 0; m3 = 0; ndone = 0;
        for (int c = 1; c <= 120; c++) begin
            @(posedge clk);
            @(negedge clk);
            if (done) begin
                ndone++;
                if (ndone == 1) begin d1 = c; m1 = int'(mag); end
                if (ndone == 2) begin d2 = c; m2 = int'(mag); end
                if (ndone == 3) begin d3 = c; m3 = int'(mag); end
            end
        end
        start = 1'b0;
        chk("held_period1", 32'(d2 - d1), 32'(N + 2));
        chk("held_period2", 32'(d3 - d2), 32'(N + 2));
        chk("held_mag1", 32'(m1), 32'd13);
        chk("held_mag3", 32'(m3), 32'd13);
        repeat (N + 4) @(posedge clk);

        // reset mid-run at k=10
        @(negedge clk);
        r00 = 4'd15; r11 = 4'd0; r10 = 4'd0; r01 = 4'd15;
        start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        repeat (10) @(posedge clk);
        @(negedge clk);
        chk("pre_rst_busy", 32'(busy), 32'd1);
        chk("pre_rst_sv", 32'(s_valid), 32'd1);
        chk("pre_rst_mag", 32'(mag), 32'd13);
        rst = 1'b1;
        #1;
        chk("midrst_busy", 32'(busy), 32'd0);
        chk("midrst_sv", 32'(s_valid), 32'd0);
        chk("midrst_done", 32'(done), 32'd0);
        chk("midrst_mag", 32'(mag), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        run_vec("after_rst", 4'd12, 4'd3, 4'd5, 4'd9, 5'd14, 13, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miscmp);
        $finish;
    end

endmodule
